// File: rtl/op_loader.sv
// Framed host byte loader for op RAM: SYNC, addr, len, data..., [cksum].
// Define OPLOAD_CKSUM_EN to require and verify the trailing checksum byte.
module op_loader #(
    parameter logic [7:0] SYNC    = 8'hA5,
    parameter int         TIMEOUT = 1023
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    output logic       write,
    output logic [7:0] writeop,
    output logic [7:0] addr,
    output logic       cpu_hold,
    output logic       busy,
    output logic       done,
    output logic       err
);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        LEN,
        DATA,
`ifdef OPLOAD_CKSUM_EN
        CKSUM,
`endif
        DONE
    } state_t;

    state_t      state;
    state_t      nxt;
    logic        accept;
    logic        waiting;
    logic        tmo_hit;
    logic        bad;
    logic [7:0]  ptr;
    logic [8:0]  cnt;
    logic [9:0]  tmo;
    logic        hold;
    logic        err_q;
`ifdef OPLOAD_CKSUM_EN
    logic [7:0]  sum;
`endif

    assign in_ready = (state != DONE);
    assign busy     = (state != IDLE);
    assign done     = (state == DONE);
    assign cpu_hold = hold;
    assign err      = err_q;
    assign accept   = in_valid && in_ready;

    // Only the mid-frame states wait on the host.
    assign waiting  = busy && !done;
    assign tmo_hit  = waiting && !accept
                    && (tmo == 10'(TIMEOUT - 1));

    always_comb begin
        nxt = state;
        bad = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept && in_data == SYNC) begin
                    nxt = ADDR;
                end
            end
            ADDR: begin
                if (accept) begin
                    nxt = LEN;
                end
            end
            LEN: begin
                if (accept) begin
                    nxt = DATA;
                end
            end
            DATA: begin
                if (accept && cnt == 9'd1) begin
`ifdef OPLOAD_CKSUM_EN
                    nxt = CKSUM;
`else
                    nxt = DONE;
`endif
                end
            end
`ifdef OPLOAD_CKSUM_EN
            CKSUM: begin
                if (accept) begin
                    if (in_data == sum) begin
                        nxt = DONE;
                    end else begin
                        nxt = IDLE;
                        bad = 1'b1;
                    end
                end
            end
`endif
            DONE: begin
                nxt = IDLE;
            end
            default: begin
                nxt = IDLE;
            end
        endcase
        // Acceptance wins over expiry: tmo_hit already excludes it.
        if (tmo_hit) begin
            nxt = IDLE;
            bad = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr     <= 8'h00;
            cnt     <= 9'd0;
            tmo     <= 10'd0;
            hold    <= 1'b0;
            err_q   <= 1'b0;
            write   <= 1'b0;
            writeop <= 8'h00;
            addr    <= 8'h00;
        end else begin
            write <= 1'b0;
            if (waiting && !accept) begin
                tmo <= tmo + 10'd1;
            end else begin
                tmo <= 10'd0;
            end
            if (accept) begin
                unique case (state)
                    IDLE: begin
                        if (in_data == SYNC) begin
                            err_q <= 1'b0;
                            hold  <= 1'b1;
                        end
                    end
                    ADDR: begin
                        ptr <= in_data;
                    end
                    LEN: begin
                        cnt <= (in_data == 8'h00) ? 9'd256
                                                  : {1'b0, in_data};
                    end
                    DATA: begin
                        write   <= 1'b1;
                        writeop <= in_data;
                        addr    <= ptr;
                        ptr     <= ptr + 8'd1;
                        cnt     <= cnt - 9'd1;
                    end
                    default: begin
                    end
                endcase
            end
            if (bad) begin
                err_q <= 1'b1;
            end
            if (nxt == DONE) begin
                hold <= 1'b0;
            end
        end
    end

`ifdef OPLOAD_CKSUM_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sum <= 8'h00;
        end else if (accept) begin
            if (state == ADDR) begin
                sum <= in_data;
            end else if (state == LEN || state == DATA) begin
                sum <= sum + in_data;
            end
        end
    end
`endif

endmodule

// File: tb/tb_op_loader.sv
// Directed bench for op_loader with a write scoreboard.
// Checksum steps are compiled in only when OPLOAD_CKSUM_EN is defined.
module tb_op_loader;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = 8'h00;
    logic       write;
    logic [7:0] writeop;
    logic [7:0] addr;
    logic       cpu_hold;
    logic       busy;
    logic       done;
    logic       err;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int wr_n = 0;
    int done_n = 0;
    logic [15:0] exp_q[$];
    int wcyc[$];

    op_loader dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .write(write),
        .writeop(writeop),
        .addr(addr),
        .cpu_hold(cpu_hold),
        .busy(busy),
        .done(done),
        .err(err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every write strobe must match the next expected {addr,data}.
    always @(negedge clk) begin
        if (rst && done === 1'b1) done_n++;
        if (rst && write === 1'b1) begin
            wr_n++;
            wcyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                check("unexpected_write", {16'h0, addr, writeop}, 32'hFFFF);
            end else begin
                check("write_addr_data", {16'h0, addr, writeop},
                      {16'h0, exp_q.pop_front()});
            end
        end
    end

    task automatic send(input logic [7:0] b);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) check("in_ready_wait", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic load(input logic [7:0] a, input logic [7:0] d[$]);
        logic [7:0] s;
        logic [7:0] p;
        s = a + 8'(d.size());
        p = a;
        foreach (d[i]) begin
            exp_q.push_back({p, d[i]});
            p = p + 8'd1;
            s = s + d[i];
        end
        send(8'hA5);
        send(a);
        send(8'(d.size()));
        foreach (d[i]) send(d[i]);
`ifdef OPLOAD_CKSUM_EN
        send(s);
`endif
        idle(3);
    endtask

    int w0, d0;

    initial begin
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_outs", {26'h0, write, cpu_hold, busy, done, err, 1'b0}, 32'd0);
        check("rst_addr_op", {16'h0, addr, writeop}, 32'd0);
        #22 rst = 1'b1;
        @(posedge clk); #1;

        // Single-byte load
        w0 = wr_n; d0 = done_n;
        exp_q.push_back({8'h10, 8'h3C});
        send(8'hA5);
        check("t1_hold_set", {30'h0, cpu_hold, busy}, 32'h3);
        send(8'h10);
        send(8'h01);
        send(8'h3C);
`ifdef OPLOAD_CKSUM_EN
        send(8'h4D);
`endif
        idle(3);
        check("t1_writes", wr_n - w0, 1);
        check("t1_done", done_n - d0, 1);
        check("t1_hold_err", {30'h0, cpu_hold, err}, 32'd0);
        check("t1_busy", 32'(busy), 32'd0);

        // Wrap and burst
        w0 = wr_n; d0 = done_n;
        wcyc.delete();
        load(8'hFE, '{8'h11, 8'h22, 8'h33});
        check("t2_writes", wr_n - w0, 3);
        check("t2_consec1", wcyc[1] - wcyc[0], 1);
        check("t2_consec2", wcyc[2] - wcyc[1], 1);
        check("t2_done", done_n - d0, 1);
        check("t2_err", 32'(err), 32'd0);

`ifdef OPLOAD_CKSUM_EN
        // Bad checksum
        w0 = wr_n; d0 = done_n;
        exp_q.push_back({8'h20, 8'h01});
        exp_q.push_back({8'h21, 8'h02});
        send(8'hA5); send(8'h20); send(8'h02);
        send(8'h01); send(8'h02); send(8'h00);
        idle(3);
        check("t3_writes", wr_n - w0, 2);
        check("t3_err_hold", {30'h0, err, cpu_hold}, 32'h3);
        check("t3_no_done", done_n - d0, 0);
        d0 = done_n;
        load(8'h60, '{8'hAB});
        check("t3_recover", {30'h0, err, cpu_hold}, 32'h0);
        check("t3_done", done_n - d0, 1);
`endif

        // Junk before sync
        w0 = wr_n; d0 = done_n;
        send(8'h00);
        send(8'hFF);
        send(8'h5A);
        idle(1);
        check("t4_junk", {29'h0, busy, cpu_hold, write}, 32'd0);
        check("t4_junk_wr", wr_n - w0, 0);
        load(8'h30, '{8'h77, 8'h88});
        check("t4_writes", wr_n - w0, 2);
        check("t4_done", done_n - d0, 1);

        // Timeout
        w0 = wr_n; d0 = done_n;
        exp_q.push_back({8'h40, 8'h9E});
        send(8'hA5); send(8'h40); send(8'h05); send(8'h9E);
        idle(1000);
        check("t5_still_busy", {30'h0, busy, err}, 32'h2);
        idle(30);
        check("t5_timeout", {29'h0, err, busy, cpu_hold}, 32'h5);
        check("t5_writes", wr_n - w0, 1);
        check("t5_no_done", done_n - d0, 0);
        load(8'h70, '{8'h01, 8'h02});
        check("t5_recover", {30'h0, err, cpu_hold}, 32'h0);

        // Reset mid-DATA
        w0 = wr_n;
        exp_q.push_back({8'h50, 8'hD0});
        exp_q.push_back({8'h51, 8'hD1});
        send(8'hA5); send(8'h50); send(8'h04);
        send(8'hD0); send(8'hD1);
        in_valid = 1'b0;
        @(negedge clk); #1;
        rst = 1'b0;
        #1;
        check("t6_rst_ready", 32'(in_ready), 32'd1);
        check("t6_rst_outs", {26'h0, write, cpu_hold, busy, done, err, 1'b0}, 32'd0);
        check("t6_rst_addr_op", {16'h0, addr, writeop}, 32'd0);
        #20 rst = 1'b1;
        idle(5);
        check("t6_writes", wr_n - w0, 2);
        check("t6_busy", 32'(busy), 32'd0);

        check("sb_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
